// File: rtl/dbus_bridge.sv
// dbus_bridge: data-bus bridge below the CPU MEM-stage port.
// Decodes each access to DRAM or to the on-board peripherals (LEDs, switches,
// buttons, 8-digit 7-segment display with scan engine).
// Optional feature macro: BRIDGE_TIMER_EN adds TIMER (0x020) and TDIV (0x024).
// Bus handshake: single-cycle, no valid/ready. A write takes effect at the edge
// on which cpu_we is sampled; read data is combinational in the same cycle.
module dbus_bridge #(
  parameter int ADDR_W        = 14,
  parameter int SCAN_DIV      = 20000,
  parameter int TIMER_DIV_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              dram_we,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [31:0]       dram_wdata,
  input  logic [31:0]       dram_rdata,
  input  logic [23:0]       sw,
  input  logic [4:0]        btn,
  output logic [23:0]       led,
  output logic [7:0]        dig_en,
  output logic [7:0]        dig_seg
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  localparam logic [11:0] OFF_DIG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_TDIV  = 12'h024;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  logic        periph;
  logic [11:0] off;
  logic        wr_dig, wr_led;
  logic        unused_addr_lsb;

  logic [31:0]      dig_q, dig_d;
  logic [23:0]      led_q, led_d;
  logic [23:0]      sw_meta_q, sw_sync_q;
  logic [4:0]       btn_meta_q, btn_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       nib;

  assign periph          = (cpu_addr[31:12] == 20'hFFFFF);
  assign off             = cpu_addr[11:0];
  assign wr_dig          = cpu_we & periph & (off == OFF_DIG);
  assign wr_led          = cpu_we & periph & (off == OFF_LED);
  assign unused_addr_lsb = ^cpu_addr[1:0];

  // DRAM side is a pure pass-through, gated only by the decode.
  assign dram_we    = cpu_we & ~periph;
  assign dram_addr  = cpu_addr[ADDR_W+1:2];
  assign dram_wdata = cpu_wdata;

`ifdef BRIDGE_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic [31:0] tdiv_q, tdiv_d;
  logic [31:0] tpre_q, tpre_d;
  logic [31:0] tdiv_eff;
  logic        wr_timer, wr_tdiv;

  assign wr_timer = cpu_we & periph & (off == OFF_TIMER);
  assign wr_tdiv  = cpu_we & periph & (off == OFF_TDIV);
  assign tdiv_eff = (tdiv_q == 32'd0) ? 32'd1 : tdiv_q;

  // Timer next state: CPU write to TIMER beats an increment; any write clears the prescaler.
  always_comb begin
    timer_d = timer_q;
    tdiv_d  = tdiv_q;
    tpre_d  = tpre_q + 32'd1;
    if (wr_timer) begin
      timer_d = cpu_wdata;
      tpre_d  = 32'd0;
    end else if (wr_tdiv) begin
      tdiv_d  = cpu_wdata;
      tpre_d  = 32'd0;
    end else if (tpre_q >= tdiv_eff - 32'd1) begin
      tpre_d  = 32'd0;
      timer_d = timer_q + 32'd1;
    end
  end

  // Timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= 32'd0;
      tdiv_q  <= 32'(TIMER_DIV_RST);
      tpre_q  <= 32'd0;
    end else begin
      timer_q <= timer_d;
      tdiv_q  <= tdiv_d;
      tpre_q  <= tpre_d;
    end
  end
`else
  localparam logic [31:0] unused_tdiv_rst = 32'(TIMER_DIV_RST);
`endif

  // Read mux: DRAM for non-peripheral addresses, register map otherwise.
  always_comb begin
    cpu_rdata = 32'd0;
    if (!periph) begin
      cpu_rdata = dram_rdata;
    end else begin
      case (off)
        OFF_DIG:   cpu_rdata = dig_q;
        OFF_LED:   cpu_rdata = {8'h0, led_q};
        OFF_SW:    cpu_rdata = {8'h0, sw_sync_q};
        OFF_BTN:   cpu_rdata = {27'h0, btn_sync_q};
`ifdef BRIDGE_TIMER_EN
        OFF_TIMER: cpu_rdata = timer_q;
        OFF_TDIV:  cpu_rdata = tdiv_q;
`endif
        default:   cpu_rdata = 32'd0;
      endcase
    end
  end

  // Next state for writable registers and the scan engine.
  always_comb begin
    dig_d = wr_dig ? cpu_wdata : dig_q;
    led_d = wr_led ? cpu_wdata[23:0] : led_q;
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Registers, including the 2-flop synchronizers for sw/btn.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q      <= 32'd0;
      led_q      <= 24'd0;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      sw_meta_q  <= 24'd0;
      sw_sync_q  <= 24'd0;
      btn_meta_q <= 5'd0;
      btn_sync_q <= 5'd0;
    end else begin
      dig_q      <= dig_d;
      led_q      <= led_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  assign led    = led_q;
  assign dig_en = ~(8'b1 << idx_q);
  assign nib    = dig_q[{idx_q, 2'b00} +: 4];

  // Hex to 7-segment (active-low, DP forced off).
  always_comb begin
    dig_seg = 8'hFF;
    case (nib)
      4'h0: dig_seg = 8'hC0;
      4'h1: dig_seg = 8'hF9;
      4'h2: dig_seg = 8'hA4;
      4'h3: dig_seg = 8'hB0;
      4'h4: dig_seg = 8'h99;
      4'h5: dig_seg = 8'h92;
      4'h6: dig_seg = 8'h82;
      4'h7: dig_seg = 8'hF8;
      4'h8: dig_seg = 8'h80;
      4'h9: dig_seg = 8'h90;
      4'hA: dig_seg = 8'h88;
      4'hB: dig_seg = 8'h83;
      4'hC: dig_seg = 8'hC6;
      4'hD: dig_seg = 8'hA1;
      4'hE: dig_seg = 8'h86;
      4'hF: dig_seg = 8'h8E;
      default: dig_seg = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// tb_dbus_bridge: randomized bench for dbus_bridge against a behavioural model.
// Honours BRIDGE_TIMER_EN the same way the design does.
module tb_dbus_bridge;

  localparam int ADDR_W   = 14;
  localparam int SCAN_DIV = 4;
  localparam int TDIV_RST = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cpu_we = 1'b0;
  logic [31:0]       cpu_addr = 32'd0;
  logic [31:0]       cpu_wdata = 32'd0;
  logic [31:0]       cpu_rdata;
  logic              dram_we;
  logic [ADDR_W-1:0] dram_addr;
  logic [31:0]       dram_wdata;
  logic [31:0]       dram_rdata = 32'd0;
  logic [23:0]       sw = 24'd0;
  logic [4:0]        btn = 5'd0;
  logic [23:0]       led;
  logic [7:0]        dig_en;
  logic [7:0]        dig_seg;

  dbus_bridge #(.ADDR_W(ADDR_W), .SCAN_DIV(SCAN_DIV), .TIMER_DIV_RST(TDIV_RST)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw(sw), .btn(btn), .led(led), .dig_en(dig_en), .dig_seg(dig_seg)
  );

  // ---------------- scoreboard / checker ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [31:0] dig_m;
  logic [23:0] led_m;
  logic [23:0] sw_q [$];
  logic [4:0]  btn_q [$];
  longint      scan_n;     // clock edges since reset
  logic [31:0] t_base;     // timer value at last TIMER/TDIV write (or reset)
  longint      t_ref;      // edges since that event
  logic [31:0] tdiv_m;

  function automatic logic [23:0] sw_sync_m();
    return (sw_q.size() >= 2) ? sw_q[sw_q.size()-2] : 24'd0;
  endfunction

  function automatic logic [4:0] btn_sync_m();
    return (btn_q.size() >= 2) ? btn_q[btn_q.size()-2] : 5'd0;
  endfunction

  function automatic logic [31:0] timer_m();
    longint eff;
    eff = (tdiv_m == 32'd0) ? 1 : longint'(tdiv_m);
    return t_base + 32'(t_ref / eff);
  endfunction

  function automatic int idx_m();
    return int'((scan_n / SCAN_DIV) % 8);
  endfunction

  function automatic logic [31:0] read_m(input logic [31:0] a);
    if (a[31:12] != 20'hFFFFF) return dram_rdata;
    case (a[11:0])
      12'h000: return dig_m;
      12'h060: return {8'h0, led_m};
      12'h070: return {8'h0, sw_sync_m()};
      12'h078: return {27'h0, btn_sync_m()};
`ifdef BRIDGE_TIMER_EN
      12'h020: return timer_m();
      12'h024: return tdiv_m;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    dig_m = 32'd0; led_m = 24'd0;
    sw_q.delete(); btn_q.delete();
    scan_n = 0;
    t_base = 32'd0; t_ref = 0; tdiv_m = 32'(TDIV_RST);
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] tnow;
    tnow = timer_m();
    sw_q.push_back(sw);
    btn_q.push_back(btn);
    if (sw_q.size() > 4) void'(sw_q.pop_front());
    if (btn_q.size() > 4) void'(btn_q.pop_front());
    scan_n++;
    t_ref++;
    if (we && a[31:12] == 20'hFFFFF) begin
      case (a[11:0])
        12'h000: dig_m = d;
        12'h060: led_m = d[23:0];
`ifdef BRIDGE_TIMER_EN
        12'h020: begin t_base = d; t_ref = 0; end
        12'h024: begin t_base = tnow; t_ref = 0; tdiv_m = d; end
`endif
        default: ;
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst = 1'b1; cpu_we = 1'b0;
    repeat (n) @(posedge clk);
    model_reset();
    #1 rst = 1'b0;
  endtask

  // One bus cycle: drive, check combinational outputs mid-cycle, take the edge.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] en_exp;
    logic [3:0] nib;
    cpu_we = we; cpu_addr = a; cpu_wdata = d;
    #3;
    en_exp = 8'hFF ^ (8'd1 << idx_m());
    nib    = 4'((dig_m >> (4 * idx_m())) & 32'hF);
    check("rdata", cpu_rdata, read_m(a));
    check("dram_we", {31'd0, dram_we}, {31'd0, we && (a[31:12] != 20'hFFFFF)});
    check("dram_addr", {18'd0, dram_addr}, {18'd0, a[ADDR_W+1:2]});
    check("dram_wdata", dram_wdata, d);
    check("led", {8'd0, led}, {8'd0, led_m});
    check("dig_en", {24'd0, dig_en}, {24'd0, en_exp});
    check("dig_seg", {24'd0, dig_seg}, {24'd0, seg_tab[nib]});
    @(posedge clk);
    model_edge(we, a, d);
    #1;
  endtask

  // Idle read with a fixed expected value taken straight from the datasheet.
  task automatic idle_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cpu_we = 1'b0; cpu_addr = a; cpu_wdata = 32'd0;
    #3;
    check(tag, cpu_rdata, exp);
    @(posedge clk);
    model_edge(1'b0, a, 32'd0);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [11:0] offs [8] = '{12'h000, 12'h060, 12'h070, 12'h078,
                              12'h020, 12'h024, 12'h004, 12'hFFC};
    if ($urandom_range(0, 2) == 0) return $urandom() & 32'h7FFF_FFFF;
    return {20'hFFFFF, offs[$urandom_range(0, 7)]};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_reset();

    // 1: reset values
    do_reset(2);
    check("t1_led", {8'd0, led}, 32'd0);
    check("t1_dig_en", {24'd0, dig_en}, 32'hFE);
    check("t1_dig_seg", {24'd0, dig_seg}, 32'hC0);
    idle_read("t1_read_led", 32'hFFFFF060, 32'd0);

    // 2: LED write, old value on same-cycle read, no DRAM write
    do_reset(2);
    cyc(1'b1, 32'hFFFFF060, 32'h00ABCDEF);
    check("t2_led", {8'd0, led}, 32'h00ABCDEF);
    idle_read("t2_read_led", 32'hFFFFF060, 32'h00ABCDEF);

    // 3: DRAM write/read path
    dram_rdata = 32'h1234;
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h55;
    #3;
    check("t3_dram_we", {31'd0, dram_we}, 32'd1);
    check("t3_dram_addr", {18'd0, dram_addr}, 32'd4);
    check("t3_dram_wdata", dram_wdata, 32'h55);
    check("t3_rdata", cpu_rdata, 32'h1234);
    @(posedge clk); model_edge(1'b1, 32'h10, 32'h55); #1;

    // 4: switch synchronizer latency
    do_reset(2);
    sw = 24'h123456;
    idle_read("t4_pre", 32'hFFFFF070, 32'd0);
    idle_read("t4_edge1", 32'hFFFFF070, 32'd0);
    idle_read("t4_edge2", 32'hFFFFF070, 32'h00123456);

    // 5: scan engine over a full rotation and a bit
    do_reset(2);
    cyc(1'b1, 32'hFFFFF000, 32'h12345678);
    check("t5_first_seg", {24'd0, dig_seg}, 32'h80);
    check("t5_first_en", {24'd0, dig_en}, 32'hFE);
    for (int i = 0; i < 40; i++) cyc(1'b0, 32'hFFFFF000, 32'd0);

`ifdef BRIDGE_TIMER_EN
    // 6: timer wrap and reset
    do_reset(2);
    cyc(1'b1, 32'hFFFFF020, 32'hFFFFFFFF);
    idle_read("t6_hold", 32'hFFFFF020, 32'hFFFFFFFF);
    idle_read("t6_wrap", 32'hFFFFF020, 32'h0);
    do_reset(2);
    idle_read("t6_rst", 32'hFFFFF020, 32'h0);
    cyc(1'b1, 32'hFFFFF024, 32'd3);
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'hFFFFF020, 32'd0);
    cyc(1'b1, 32'hFFFFF024, 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'hFFFFF020, 32'd0);
`else
    idle_read("t6_no_timer", 32'hFFFFF020, 32'h0);
    cyc(1'b1, 32'hFFFFF024, 32'h77);
    idle_read("t6_no_tdiv", 32'hFFFFF024, 32'h0);
`endif

    // randomized traffic, occasional mid-scan reset
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      dram_rdata = $urandom();
      if ($urandom_range(0, 7) == 0) sw = 24'($urandom());
      if ($urandom_range(0, 7) == 0) btn = 5'($urandom());
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        logic [31:0] a;
        logic [31:0] d;
        a = rand_addr();
        d = $urandom();
        if (a[11:0] == 12'h024 && $urandom_range(0, 1) == 0) d = 32'($urandom_range(0, 5));
        cyc(1'($urandom_range(0, 1)), a, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
